// File: rtl/core_pkg.sv
// Shared encodings for the core: sequencer state codes, trap causes and the
// RV32I major opcodes that decode matches against.
package core_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_MEM     = 3'd4;
  localparam logic [2:0] ST_WB      = 3'd5;
  localparam logic [2:0] ST_TRAP    = 3'd6;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_ILLEGAL  = 2'b01,
    CAUSE_IMEM_TMO = 2'b10,
    CAUSE_DMEM_TMO = 2'b11
  } trap_cause_e;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;

  function automatic logic is_busy_state(input logic [2:0] st);
    return !((st == ST_IDLE) || (st == ST_TRAP));
  endfunction

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Wait-cycle counter shared by the fetch and data-memory waits; expired is
// raised once TMO_CYCLES not-ready cycles have been counted.
module wait_timer #(
  parameter int TMO_CYCLES = 255,
  parameter int TMO_BITS   = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_BITS-1:0] TMO_LIMIT = TMO_BITS'(TMO_CYCLES);

  logic [TMO_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TMO_BITS'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == TMO_LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer: turns decode controls into
// one-cycle commit strobes, bounds memory waits and counts retirements.
module core_sequencer
  import core_pkg::*;
#(
  parameter int CNT_BITS   = 32,
  parameter int TMO_CYCLES = 255,
  parameter int TMO_BITS   = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                halt_req,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                dec_wEn,
  input  logic                dec_mem_wEn,
  input  logic                dec_wb_sel,
  input  logic                dec_next_PC_select,
  input  logic                dec_illegal,
  output logic                imem_req,
  output logic                ir_load,
  output logic                dmem_req,
  output logic                dmem_wEn,
  output logic                rf_wEn,
  output logic                pc_write,
  output logic                pc_sel,
  output logic                busy,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_BITS-1:0] retired
);

  logic [2:0]          state_q, state_d;
  logic                halt_pending_q, halt_pending_d;
  logic [CNT_BITS-1:0] retired_q, retired_d;
  logic [1:0]          trap_cause_q, trap_cause_d;
  logic                tmr_clear, tmr_enable, tmr_expired;

  wait_timer #(
    .TMO_CYCLES(TMO_CYCLES),
    .TMO_BITS  (TMO_BITS)
  ) u_wait_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    retired_d    = retired_q;
    trap_cause_d = trap_cause_q;
    tmr_clear    = 1'b1;
    tmr_enable   = 1'b0;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_wEn     = 1'b0;
    rf_wEn       = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        // Ready beats the timeout even in the cycle the limit is reached.
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_IMEM_TMO;
        end else begin
          tmr_clear  = 1'b0;
          tmr_enable = 1'b1;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = (dec_wb_sel || dec_mem_wEn) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_wEn = dec_mem_wEn;
        if (dmem_ready) begin
          state_d = ST_WB;
        end else if (tmr_expired) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_DMEM_TMO;
        end else begin
          tmr_clear  = 1'b0;
          tmr_enable = 1'b1;
        end
      end
      ST_WB: begin
        rf_wEn    = dec_wEn;
        pc_write  = 1'b1;
        pc_sel    = dec_next_PC_select;
        retired_d = retired_q + CNT_BITS'(1);
        state_d   = (halt_req || halt_pending_q) ? ST_IDLE : ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A halt accepted together with start is held so that instruction retires first.
  always_comb begin
    if (state_d == ST_IDLE) begin
      halt_pending_d = 1'b0;
    end else begin
      halt_pending_d = halt_pending_q |
                       (halt_req & (busy | ((state_q == ST_IDLE) & start)));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      halt_pending_q <= 1'b0;
      retired_q      <= '0;
      trap_cause_q   <= CAUSE_NONE;
    end else begin
      state_q        <= state_d;
      halt_pending_q <= halt_pending_d;
      retired_q      <= retired_d;
      trap_cause_q   <= trap_cause_d;
    end
  end

  assign busy       = is_busy_state(state_q);
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = trap_cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a per-cycle vector table for the basic
// instruction flows plus hand-written waits, timeouts, halt, reset and wrap.
module tb_core_sequencer;

  localparam int CNT_BITS   = 3;
  localparam int TMO_CYCLES = 4;
  localparam int TMO_BITS   = 3;

  logic clock, reset_n;
  logic start, halt_req, imem_ready, dmem_ready;
  logic dec_wEn, dec_mem_wEn, dec_wb_sel, dec_next_PC_select, dec_illegal;
  logic imem_req, ir_load, dmem_req, dmem_wEn, rf_wEn, pc_write, pc_sel, busy, trap;
  logic [1:0] trap_cause;
  logic [CNT_BITS-1:0] retired;

  int tests_run = 0;
  int tests_failed = 0;

  core_sequencer #(
    .CNT_BITS  (CNT_BITS),
    .TMO_CYCLES(TMO_CYCLES),
    .TMO_BITS  (TMO_BITS)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .halt_req          (halt_req),
    .imem_ready        (imem_ready),
    .dmem_ready        (dmem_ready),
    .dec_wEn           (dec_wEn),
    .dec_mem_wEn       (dec_mem_wEn),
    .dec_wb_sel        (dec_wb_sel),
    .dec_next_PC_select(dec_next_PC_select),
    .dec_illegal       (dec_illegal),
    .imem_req          (imem_req),
    .ir_load           (ir_load),
    .dmem_req          (dmem_req),
    .dmem_wEn          (dmem_wEn),
    .rf_wEn            (rf_wEn),
    .pc_write          (pc_write),
    .pc_sel            (pc_sel),
    .busy              (busy),
    .trap              (trap),
    .trap_cause        (trap_cause),
    .retired           (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {imem_req, ir_load, dmem_req, dmem_wEn, rf_wEn, pc_write, pc_sel, busy}
  typedef struct {
    string      name;
    logic       st, hr, imr, dmr, w, mw, wb, np, il;
    logic [7:0] strb;
    logic [2:0] ret;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic st, hr, imr, dmr, w, mw, wb, np, il,
                     input logic [7:0] strb, input logic [2:0] ret);
    vec_t v;
    v.name = nm; v.st = st; v.hr = hr; v.imr = imr; v.dmr = dmr;
    v.w = w; v.mw = mw; v.wb = wb; v.np = np; v.il = il;
    v.strb = strb; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_dec(input logic w, mw, wb, np, il);
    dec_wEn = w; dec_mem_wEn = mw; dec_wb_sel = wb; dec_next_PC_select = np; dec_illegal = il;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  // Starts one instruction (halt requested with start so it ends in IDLE) and
  // tallies strobe cycles until busy drops; memory ready is given after the
  // requested number of wait cycles (99 = never).
  task automatic run_instr(input logic w, mw, wb, np, il, input int iw, input int dw,
                           output int n_busy, output int n_imem, output int n_irl,
                           output int n_dreq, output int n_dwen, output int n_rf,
                           output int n_pcw, output logic ok);
    int fi, mi;
    fi = 0; mi = 0;
    n_busy = 0; n_imem = 0; n_irl = 0; n_dreq = 0; n_dwen = 0; n_rf = 0; n_pcw = 0;
    ok = 1'b0;
    set_dec(w, mw, wb, np, il);
    start = 1'b1; halt_req = 1'b1;
    step();
    start = 1'b0; halt_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      imem_ready = imem_req && (fi == iw);
      dmem_ready = dmem_req && (mi == dw);
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      n_busy++;
      if (imem_req) begin n_imem++; fi++; end
      if (dmem_req) begin n_dreq++; mi++; end
      if (ir_load)  n_irl++;
      if (dmem_wEn) n_dwen++;
      if (rf_wEn)   n_rf++;
      if (pc_write) n_pcw++;
      step();
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    if (ok) step();
  endtask

  logic [10:0] act_v;
  int nb, ni, nl, nd, ndw, nr, np_c;
  logic ok;
  int k;

  initial begin
    reset_n = 1'b0;
    start = 1'b0; halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset: strobes stay low even with start/ready asserted.
    #1;
    start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("rst_strobes", {imem_req, ir_load, dmem_req, dmem_wEn, rf_wEn, pc_write, pc_sel, busy}, 8'h00);
    chk("rst_trap", {trap, trap_cause}, 3'b000);
    chk("rst_retired", retired, 0);
    start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    reset_n = 1'b1;
    step();

    //    name          st hr ir dr  w mw wb np il  strobes ret
    add("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    add("start",       1, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0);
    add("add_fetch",   0, 0, 1, 0, 1, 0, 0, 0, 0, 8'hC1, 0);
    add("add_dec",     0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h01, 0);
    add("add_exe",     0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h01, 0);
    add("add_wb",      0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h0D, 0);
    add("beq_fetch",   0, 0, 1, 0, 0, 0, 0, 1, 0, 8'hC1, 1);
    add("beq_dec",     0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 1);
    add("beq_exe",     0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 1);
    add("beq_wb",      0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h07, 1);
    add("sw_fetch",    0, 0, 1, 0, 0, 1, 0, 0, 0, 8'hC1, 2);
    add("sw_dec",      0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h01, 2);
    add("sw_exe_rdy",  0, 0, 1, 1, 0, 1, 0, 0, 0, 8'h01, 2);
    add("sw_mem",      0, 0, 1, 1, 0, 1, 0, 0, 0, 8'h31, 2);
    add("sw_wb",       0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h05, 2);
    add("halt_fetch",  0, 0, 1, 0, 1, 0, 0, 0, 0, 8'hC1, 3);
    add("halt_dec",    0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h01, 3);
    add("halt_exe",    0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h01, 3);
    add("halt_wb",     0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h0D, 3);
    add("halt_idle",   0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 4);
    add("idle_hold",   0, 0, 1, 1, 1, 0, 0, 0, 0, 8'h00, 4);

    foreach (vecs[i]) begin
      start = vecs[i].st; halt_req = vecs[i].hr;
      imem_ready = vecs[i].imr; dmem_ready = vecs[i].dmr;
      set_dec(vecs[i].w, vecs[i].mw, vecs[i].wb, vecs[i].np, vecs[i].il);
      @(negedge clock);
      act_v = {imem_req, ir_load, dmem_req, dmem_wEn, rf_wEn, pc_write, pc_sel, busy,
               trap, trap_cause};
      chk({vecs[i].name, "_outs"}, act_v, {vecs[i].strb, 3'b000});
      chk({vecs[i].name, "_ret"}, retired, vecs[i].ret);
      step();
    end
    start = 1'b0; halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;

    // LW: one fetch wait, two data waits; start+halt together returns to IDLE.
    run_instr(1, 0, 1, 0, 0, 1, 2, nb, ni, nl, nd, ndw, nr, np_c, ok);
    chk("lw_done", ok, 1);
    chk("lw_busy_cycles", nb, 8);
    chk("lw_dmem_req", nd, 3);
    chk("lw_dmem_wen", ndw, 0);
    chk("lw_rf_wen", nr, 1);
    chk("lw_retired", retired, 5);
    chk("lw_state", {busy, trap}, 2'b00);

    // Ready arrives in the cycle the timer hits the limit: no trap.
    run_instr(1, 0, 0, 0, 0, 4, 0, nb, ni, nl, nd, ndw, nr, np_c, ok);
    chk("lim_done", ok, 1);
    chk("lim_fetch_cycles", ni, 5);
    chk("lim_ir_load", nl, 1);
    chk("lim_trap", {trap, trap_cause}, 3'b000);
    chk("lim_retired", retired, 6);

    // Reset asserted mid-MEM clears strobes and the counter at once.
    set_dec(1, 0, 1, 0, 0);
    start = 1'b1; halt_req = 1'b1;
    step();
    start = 1'b0; halt_req = 1'b0; imem_ready = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(negedge clock);
      if (dmem_req) break;
      step();
    end
    chk("rmem_reached_mem", (k < 10), 1);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rmem_dmem_req", dmem_req, 0);
    chk("rmem_retired", retired, 0);
    chk("rmem_busy", busy, 0);
    imem_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Counter wrap at 2^CNT_BITS.
    for (int i = 0; i < 7; i++) begin
      run_instr(1, 0, 0, 0, 0, 0, 0, nb, ni, nl, nd, ndw, nr, np_c, ok);
    end
    chk("wrap_at_max", retired, 7);
    run_instr(1, 0, 0, 0, 0, 0, 0, nb, ni, nl, nd, ndw, nr, np_c, ok);
    chk("wrap_to_zero", retired, 0);
    chk("alu_busy_cycles", nb, 4);

    // Data-memory timeout on a store.
    run_instr(0, 1, 0, 0, 0, 0, 99, nb, ni, nl, nd, ndw, nr, np_c, ok);
    chk("dtmo_stopped", ok, 1);
    chk("dtmo_dmem_req", nd, 5);
    chk("dtmo_dmem_wen", ndw, 5);
    chk("dtmo_trap", {trap, trap_cause, busy}, 4'b1110);
    chk("dtmo_no_retire", retired, 0);
    do_reset();

    // Instruction-fetch timeout: 4 counted waits then the trap decision.
    run_instr(1, 0, 0, 0, 0, 99, 0, nb, ni, nl, nd, ndw, nr, np_c, ok);
    chk("itmo_stopped", ok, 1);
    chk("itmo_fetch_cycles", ni, 5);
    chk("itmo_ir_load", nl, 0);
    chk("itmo_trap", {trap, trap_cause, busy}, 4'b1100);
    start = 1'b1; imem_ready = 1'b1;
    step();
    start = 1'b0;
    @(negedge clock);
    chk("itmo_start_ignored", {imem_req, ir_load, busy, trap}, 4'b0001);
    imem_ready = 1'b0;
    do_reset();

    // Illegal instruction traps out of DECODE.
    run_instr(1, 0, 0, 0, 1, 0, 0, nb, ni, nl, nd, ndw, nr, np_c, ok);
    chk("ill_stopped", ok, 1);
    chk("ill_busy_cycles", nb, 2);
    chk("ill_trap", {trap, trap_cause, busy}, 4'b1010);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    @(negedge clock);
    chk("ill_sticky", {trap, trap_cause, imem_req, busy}, 5'b10100);
    set_dec(0, 0, 0, 0, 0);
    do_reset();
    @(negedge clock);
    chk("ill_reset_clears", {trap, trap_cause, busy}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
